switch_debouncer: RTL and testbench
===================================

SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 The block SHALL provide parameter STABLE_CYCLES, default 16, as the number of consecutive synchronized samples required to accept a new level; legal values are 2 to 2^20.
REQ-002 The block SHALL provide parameter CNT_W, default 5, as the stability counter width; CNT_W SHALL satisfy 2^CNT_W > STABLE_CYCLES.
REQ-003 clock  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 din_raw  input  1  asynchronous, bouncing switch or key level.
REQ-006 q  output  1  debounced level; drives the d input of the downstream negative-edge D flip-flop stage.
REQ-007 rise  output  1  one-cycle pulse on an accepted 0->1 change of q.
REQ-008 fall  output  1  one-cycle pulse on an accepted 1->0 change of q.
REQ-009 busy  output  1  high while a candidate level change is being qualified.
REQ-010 bounce_cnt  output  8  saturating count of aborted qualifications.

Function
REQ-011 din_raw SHALL pass through a two-flop synchronizer (s1 <= din_raw, s2 <= s1); only s2 SHALL feed the state machine.
REQ-012 The state machine SHALL have four states: LOW, CHK_HIGH, HIGH, CHK_LOW.
REQ-013 In LOW: s2=1 -> CHK_HIGH with cnt <= 1; otherwise stay in LOW with cnt <= 0.
REQ-014 In CHK_HIGH: s2=0 -> LOW, cnt <= 0, bounce_cnt increments; s2=1 and cnt=STABLE_CYCLES-1 -> HIGH, q <= 1, rise <= 1, cnt <= 0; otherwise cnt <= cnt+1.
REQ-015 HIGH and CHK_LOW SHALL mirror REQ-013 and REQ-014 with polarities inverted, and an accepted change SHALL drive q <= 0 and fall <= 1.
REQ-016 q SHALL change only on acceptance, i.e. after STABLE_CYCLES consecutive equal s2 samples that differ from q.
REQ-017 Latency: a din_raw change set up before rising edge E0 and held SHALL appear on q after edge E(STABLE_CYCLES+1).
REQ-018 rise and fall SHALL be registered, high for exactly one cycle in the same cycle q first shows its new value, and never high together.
REQ-019 busy SHALL be high exactly while the state is CHK_HIGH or CHK_LOW.
REQ-020 bounce_cnt SHALL saturate at 255 and hold; it SHALL never wrap.
REQ-021 A glitch shorter than STABLE_CYCLES samples SHALL leave q, rise and fall unchanged.
REQ-022 All outputs SHALL be registered and SHALL change only on the rising edge, so q is stable at the downstream falling edge.

Reset
REQ-023 When resetn=0 at a rising edge, the block SHALL set: s1=0, s2=0, state=LOW, cnt=0, q=0, rise=0, fall=0, busy=0, bounce_cnt=0.
REQ-024 Reset SHALL override every other transition, including an acceptance due in the same cycle; an aborted qualification SHALL NOT pulse rise or fall and SHALL NOT increment bounce_cnt.
REQ-025 If din_raw=1 at reset release, the block SHALL qualify it normally: q rises after STABLE_CYCLES+2 edges and rise pulses once.

Verification (STABLE_CYCLES=4)
REQ-026 Clean press: with resetn=1 and din_raw 0->1 before edge E0 and held, the bench SHALL see q=1 and rise=1 after E5, rise=0 after E6, and busy high after E2..E4.
REQ-027 Bounce: din_raw pattern 1,0,1,0 each lasting 1 cycle, then held at 1, SHALL give exactly one rise, q=1 only after the 4-sample stable run, and bounce_cnt=2.
REQ-028 Release: from q=1, din_raw 1->0 held SHALL give q=0 and fall=1 after E5, with rise remaining 0 throughout.
REQ-029 Reset mid-check: resetn=0 for one edge while busy=1 SHALL give every output 0 on the next cycle and no rise pulse; with din_raw still 1, q SHALL rise 6 edges after reset release.
REQ-030 Saturation: 300 aborted qualifications (1-cycle pulses spaced 3 cycles apart) SHALL leave bounce_cnt=255 and q=0.

Source files
------------

// File: rtl/switch_debouncer.sv
// switch_debouncer: synchronizes a bouncing switch level and accepts a new
// level only after STABLE_CYCLES consecutive equal synchronized samples.
// It provides edge pulses, a busy flag and a saturating count of aborted
// qualifications. Every output is a flop that updates on the rising edge,
// so q is already settled when the downstream negative-edge stage samples it.
module switch_debouncer #(
  parameter int STABLE_CYCLES = 16,  // samples needed to accept a level (2 .. 2^20)
  parameter int CNT_W         = 5    // must satisfy 2^CNT_W > STABLE_CYCLES
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       din_raw,
  output logic       q,
  output logic       rise,
  output logic       fall,
  output logic       busy,
  output logic [7:0] bounce_cnt
);

  typedef enum logic [1:0] {
    S_LOW      = 2'd0,
    S_CHK_HIGH = 2'd1,
    S_HIGH     = 2'd2,
    S_CHK_LOW  = 2'd3
  } state_t;

  // The candidate is accepted when the count reaches this value while the
  // synchronized sample still agrees. The count was set to 1 on entry to a
  // check state, so acceptance happens on the STABLE_CYCLES-th agreeing sample.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [7:0]       BNC_MAX  = 8'hFF;

  logic             s1_q;
  logic             s2_q;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             q_q;
  logic             rise_q;
  logic             fall_q;
  logic             busy_q;
  logic [7:0]       bounce_cnt_q;

  // Two-flop synchronizer. Only s2_q is used by the state machine.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= din_raw;
      s2_q <= s1_q;
    end
  end

  // Qualification FSM. All outputs are registered here, and reset takes
  // precedence over an acceptance that would otherwise happen in the same cycle.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= S_LOW;
      cnt_q        <= '0;
      q_q          <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      busy_q       <= 1'b0;
      bounce_cnt_q <= '0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        S_LOW: begin
          if (s2_q) begin
            state_q <= S_CHK_HIGH;
            cnt_q   <= CNT_ONE;
            busy_q  <= 1'b1;
          end else begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end
        end
        S_CHK_HIGH: begin
          if (!s2_q) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            if (bounce_cnt_q != BNC_MAX) bounce_cnt_q <= bounce_cnt_q + 8'd1;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= S_HIGH;
            cnt_q   <= '0;
            q_q     <= 1'b1;
            rise_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
          end
        end
        S_HIGH: begin
          if (!s2_q) begin
            state_q <= S_CHK_LOW;
            cnt_q   <= CNT_ONE;
            busy_q  <= 1'b1;
          end else begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end
        end
        S_CHK_LOW: begin
          if (s2_q) begin
            state_q <= S_HIGH;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            if (bounce_cnt_q != BNC_MAX) bounce_cnt_q <= bounce_cnt_q + 8'd1;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
            q_q     <= 1'b0;
            fall_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= S_LOW;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign q          = q_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign busy       = busy_q;
  assign bounce_cnt = bounce_cnt_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with STABLE_CYCLES=4. Inputs are driven
// and outputs sampled 1 time unit after each rising edge.
module tb_switch_debouncer;

  logic       clock;
  logic       resetn;
  logic       din_raw;
  logic       q;
  logic       rise;
  logic       fall;
  logic       busy;
  logic [7:0] bounce_cnt;

  int checks;
  int errors;
  int rise_seen;
  int fall_seen;

  switch_debouncer #(
    .STABLE_CYCLES(4),
    .CNT_W        (3)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .din_raw   (din_raw),
    .q         (q),
    .rise      (rise),
    .fall      (fall),
    .busy      (busy),
    .bounce_cnt(bounce_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then sample. Also tracks pulses and checks that
  // rise and fall are never high together.
  task automatic tick();
    @(posedge clock);
    #1;
    if (rise === 1'b1) rise_seen++;
    if (fall === 1'b1) fall_seen++;
    check("rise_fall_excl", {31'd0, rise & fall}, 32'd0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rise_seen = 0;
    fall_seen = 0;
    resetn    = 1'b0;
    din_raw   = 1'b0;

    // Reset state
    ticks(2);
    check("rst_q", {31'd0, q}, 32'd0);
    check("rst_rise", {31'd0, rise}, 32'd0);
    check("rst_fall", {31'd0, fall}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_bounce", {24'd0, bounce_cnt}, 32'd0);
    resetn = 1'b1;
    ticks(2);

    // Clean press: din=1 before E0
    din_raw   = 1'b1;
    rise_seen = 0;
    tick();  // E0
    check("press_E0_busy", {31'd0, busy}, 32'd0);
    tick();  // E1
    check("press_E1_busy", {31'd0, busy}, 32'd0);
    tick();  // E2
    check("press_E2_busy", {31'd0, busy}, 32'd1);
    tick();  // E3
    check("press_E3_busy", {31'd0, busy}, 32'd1);
    tick();  // E4
    check("press_E4_busy", {31'd0, busy}, 32'd1);
    check("press_E4_q", {31'd0, q}, 32'd0);
    tick();  // E5
    check("press_E5_q", {31'd0, q}, 32'd1);
    check("press_E5_rise", {31'd0, rise}, 32'd1);
    check("press_E5_busy", {31'd0, busy}, 32'd0);
    tick();  // E6
    check("press_E6_rise", {31'd0, rise}, 32'd0);
    check("press_E6_q", {31'd0, q}, 32'd1);
    check("press_rise_count", rise_seen, 32'd1);

    // Release: din=0 held
    din_raw   = 1'b0;
    rise_seen = 0;
    fall_seen = 0;
    ticks(2);  // E0,E1
    check("rel_E1_busy", {31'd0, busy}, 32'd0);
    ticks(3);  // E2..E4
    check("rel_E4_q", {31'd0, q}, 32'd1);
    check("rel_E4_busy", {31'd0, busy}, 32'd1);
    tick();    // E5
    check("rel_E5_q", {31'd0, q}, 32'd0);
    check("rel_E5_fall", {31'd0, fall}, 32'd1);
    tick();    // E6
    check("rel_E6_fall", {31'd0, fall}, 32'd0);
    check("rel_rise_count", rise_seen, 32'd0);
    check("rel_fall_count", fall_seen, 32'd1);
    check("rel_bounce", {24'd0, bounce_cnt}, 32'd0);

    // Bounce: 1,0,1,0 for one cycle each, then held at 1.
    // The FSM sees din from two edges earlier: 1@A2, 0@A3, 1@A4, 0@A5,
    // then 1 from A6, so acceptance lands on A9.
    rise_seen = 0;
    din_raw = 1'b1; tick();  // A0
    din_raw = 1'b0; tick();  // A1
    din_raw = 1'b1; tick();  // A2
    din_raw = 1'b0; tick();  // A3
    din_raw = 1'b1;
    ticks(5);                // A4..A8
    check("bnc_A8_q", {31'd0, q}, 32'd0);
    check("bnc_A8_rise_count", rise_seen, 32'd0);
    tick();                  // A9
    check("bnc_A9_q", {31'd0, q}, 32'd1);
    check("bnc_A9_rise", {31'd0, rise}, 32'd1);
    ticks(4);
    check("bnc_rise_count", rise_seen, 32'd1);
    check("bnc_bounce", {24'd0, bounce_cnt}, 32'd2);

    // Return low, then reset in the middle of a new qualification
    din_raw = 1'b0;
    ticks(8);
    check("pre_rst_q", {31'd0, q}, 32'd0);
    din_raw   = 1'b1;
    rise_seen = 0;
    ticks(3);  // E0..E2 -> checking
    check("midrst_busy_before", {31'd0, busy}, 32'd1);
    resetn = 1'b0;
    tick();
    check("midrst_q", {31'd0, q}, 32'd0);
    check("midrst_rise", {31'd0, rise}, 32'd0);
    check("midrst_fall", {31'd0, fall}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_bounce", {24'd0, bounce_cnt}, 32'd0);
    resetn = 1'b1;
    ticks(5);  // R1..R5
    check("midrst_R5_q", {31'd0, q}, 32'd0);
    check("midrst_R5_rise_count", rise_seen, 32'd0);
    tick();    // R6
    check("midrst_R6_q", {31'd0, q}, 32'd1);
    check("midrst_R6_rise", {31'd0, rise}, 32'd1);
    check("midrst_bounce_after", {24'd0, bounce_cnt}, 32'd0);

    // Go low again, then 300 one-cycle pulses spaced 3 cycles apart
    din_raw = 1'b0;
    ticks(8);
    check("sat_start_q", {31'd0, q}, 32'd0);
    check("sat_start_bounce", {24'd0, bounce_cnt}, 32'd0);
    rise_seen = 0;
    for (int p = 0; p < 300; p++) begin
      din_raw = 1'b1; tick();
      din_raw = 1'b0; ticks(2);
      if (p == 9) begin
        // pulse 9 is seen as 1 two edges later and aborted on the third
        ticks(1);
        check("sat_bounce_10", {24'd0, bounce_cnt}, 32'd10);
      end
    end
    ticks(4);
    check("sat_bounce", {24'd0, bounce_cnt}, 32'd255);
    check("sat_q", {31'd0, q}, 32'd0);
    check("sat_rise_count", rise_seen, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
